spatial_sequencer: RTL
======================

Name: spatial_sequencer

Overview:
- Drives the input side of spatial_accumulator. Accepts one frame of CHANNELS quantised feature values over a valid/ready handshake.
- Replays the frame to the accumulator one channel per cycle. For each channel it presents the channel's item hypervector (the seed rotated by the channel index) and that channel's feature.
- After the accumulator latency it pulses a done flag so downstream logic can sample the bundled spatial hypervector.

Parameters:
- DIM, `HV_DIMENSION: hypervector width in bits.
- CH_W, `CHANNEL_WIDTH: width of one feature value.
- CHANNELS, 4: channels per frame. Legal range is 2 or more.
- ACC_LATENCY, 1: cycles from the last Enable_SO cycle until the accumulator output is valid. Legal range is 1 or more.

Ports:
- Clk_CI  in  1  clock; all logic on the rising edge.
- Reset_RI  in  1  synchronous reset, active-high.
- FeaturesValid_SI  in  1  frame valid.
- FeaturesReady_SO  out  1  block can accept a frame.
- Features_DI  in  CHANNELS*CH_W  frame. Channel k occupies bits [k*CH_W +: CH_W], so channel 0 is in the LSBs.
- SeedHV_DI  in  [0:DIM-1]  item-memory seed. Sampled only when a frame is accepted.
- Enable_SO  out  1  connects to the accumulator Enable_SI.
- FirstHypervector_SO  out  1  connects to the accumulator FirstHypervector_SI.
- HypervectorOut_DO  out  [0:DIM-1]  connects to the accumulator HypervectorIn_DI.
- FeatureOut_DO  out  CH_W  connects to the accumulator FeatureIn_DI.
- ChannelIdx_DO  out  clog2(CHANNELS)  index of the channel currently presented.
- AccDone_SO  out  1  one-cycle pulse: the accumulator output is valid this cycle.

Behaviour:
- States: IDLE, FEED, WAIT, DONE. State, channel counter, wait counter, frame register and rotate register are all flops.
- Reset (synchronous, any state, including mid-frame):
  - state=IDLE, counters=0, frame and rotate registers cleared, captured frame discarded.
  - Outputs from the following cycle: FeaturesReady_SO=1, Enable_SO=0, FirstHypervector_SO=0, HypervectorOut_DO=0, FeatureOut_DO=0, ChannelIdx_DO=0, AccDone_SO=0.
- IDLE:
  - FeaturesReady_SO=1; all other outputs 0.
  - Handshake: a frame is accepted on an edge where FeaturesValid_SI and FeaturesReady_SO are both 1.
  - On accept: frame_q<=Features_DI, rot_q<=SeedHV_DI, ch<=0, go to FEED.
- FEED (exactly CHANNELS cycles):
  - FeaturesReady_SO=0, Enable_SO=1.
  - FirstHypervector_SO=1 only when ch==0.
  - HypervectorOut_DO=rot_q.
  - FeatureOut_DO=frame_q[ch*CH_W +: CH_W].
  - ChannelIdx_DO=ch.
  - Each cycle rot_q is rotated right by one: new bit 0 = old bit DIM-1; new bit i = old bit i-1. Channel k therefore sees the seed rotated right by k.
  - When ch==CHANNELS-1: go to WAIT with wcnt<=ACC_LATENCY-1. Otherwise ch<=ch+1.
- WAIT (exactly ACC_LATENCY cycles):
  - All outputs 0, FeaturesReady_SO=0.
  - When wcnt==0, go to DONE. Otherwise decrement wcnt.
- DONE (exactly 1 cycle):
  - AccDone_SO=1; all other outputs 0, FeaturesReady_SO=0.
  - Next state is IDLE.
- Throughput: one frame per CHANNELS+ACC_LATENCY+2 cycles at best; back-to-back frames are never overlapped.
- Boundary conditions:
  - FeaturesValid_SI while not ready is ignored and has no side effect. The source must hold the frame until accepted.
  - Changes on Features_DI or SeedHV_DI after acceptance do not affect the frame in flight.
  - ch wraps only by leaving FEED and never exceeds CHANNELS-1.

Test Plan (DIM=8, CH_W=4, CHANNELS=4, ACC_LATENCY=1 unless noted):
- Reset then idle:
  - Stimulus: Reset_RI high for 2 cycles, then low, with FeaturesValid_SI=0.
  - Response: FeaturesReady_SO=1; Enable_SO, AccDone_SO and all data outputs 0 for 20 cycles.
- Single frame:
  - Stimulus: Features_DI=16'h4321, SeedHV_DI=8'b10000001, valid for one cycle.
  - Response over the next 4 cycles: Enable_SO=1111; FirstHypervector_SO=1000; FeatureOut_DO=1,2,3,4; HypervectorOut_DO=10000001, 11000000, 01100000, 00110000.
  - Then 1 idle cycle, then AccDone_SO=1 for exactly 1 cycle, then FeaturesReady_SO=1.
- Input stability:
  - Stimulus: accept a frame, then change Features_DI to 16'hFFFF and SeedHV_DI to 8'h00 during FEED.
  - Response: outputs identical to the single-frame case.
- Back-to-back frames:
  - Stimulus: FeaturesValid_SI held high with 16'h4321 then 16'h8765.
  - Response: second FEED starts exactly 7 cycles after the first. FirstHypervector_SO is high exactly once per frame. Second FeatureOut_DO sequence is 5,6,7,8.
- Reset mid-frame:
  - Stimulus: assert Reset_RI while ch==2.
  - Response: next cycle in IDLE with all outputs 0 and no AccDone_SO pulse. A new frame then runs cleanly from channel 0.
- Latency variation:
  - Stimulus: ACC_LATENCY=3, CHANNELS=2.
  - Response: AccDone_SO rises exactly 3 cycles after the last Enable_SO cycle.
  - End-to-end check with spatial_accumulator connected: the accumulator output sampled on the AccDone_SO cycle matches a golden model.

Source files
------------

// File: rtl/spatial_sequencer.sv
// Feeds one frame of quantised channel features into the spatial accumulator,
// one channel per cycle with the rotated seed as item hypervector, then flags completion.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a frame; all accumulator-side outputs held at 0
// FEED    | presenting channel ch with the seed rotated right by ch
// WAIT    | letting the accumulator settle for ACC_LATENCY cycles
// DONE    | one-cycle AccDone_SO pulse, accumulator output is valid
module spatial_sequencer #(
    parameter int DIM         = 8,
    parameter int CH_W        = 4,
    parameter int CHANNELS    = 4,
    parameter int ACC_LATENCY = 1
) (
    input  logic                       Clk_CI,
    input  logic                       Reset_RI,
    input  logic                       FeaturesValid_SI,
    output logic                       FeaturesReady_SO,
    input  logic [CHANNELS*CH_W-1:0]   Features_DI,
    input  logic [0:DIM-1]             SeedHV_DI,
    output logic                       Enable_SO,
    output logic                       FirstHypervector_SO,
    output logic [0:DIM-1]             HypervectorOut_DO,
    output logic [CH_W-1:0]            FeatureOut_DO,
    output logic [$clog2(CHANNELS)-1:0] ChannelIdx_DO,
    output logic                       AccDone_SO
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int WC_W  = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          ch_q;
    logic [WC_W-1:0]           wcnt_q;
    logic [CHANNELS*CH_W-1:0]  frame_q;
    logic [0:DIM-1]            rot_q;
    logic [0:DIM-1]            rot_nxt;
    logic [IDX_W-1:0]          ch_nxt;

    // Rotate right by one in the ascending bit order: bit 0 takes the old last bit.
    assign rot_nxt = {rot_q[DIM-1], rot_q[0:DIM-2]};
    assign ch_nxt  = ch_q + IDX_W'(1);

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q             <= ST_IDLE;
            ch_q                <= '0;
            wcnt_q              <= '0;
            frame_q             <= '0;
            rot_q               <= '0;
            FeaturesReady_SO    <= 1'b1;
            Enable_SO           <= 1'b0;
            FirstHypervector_SO <= 1'b0;
            HypervectorOut_DO   <= '0;
            FeatureOut_DO       <= '0;
            ChannelIdx_DO       <= '0;
            AccDone_SO          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (FeaturesValid_SI && FeaturesReady_SO) begin
                        frame_q             <= Features_DI;
                        rot_q               <= SeedHV_DI;
                        ch_q                <= '0;
                        state_q             <= ST_FEED;
                        FeaturesReady_SO    <= 1'b0;
                        Enable_SO           <= 1'b1;
                        FirstHypervector_SO <= 1'b1;
                        HypervectorOut_DO   <= SeedHV_DI;
                        FeatureOut_DO       <= Features_DI[CH_W-1:0];
                        ChannelIdx_DO       <= '0;
                    end
                end
                ST_FEED: begin
                    rot_q               <= rot_nxt;
                    FirstHypervector_SO <= 1'b0;
                    if (ch_q == LAST_CH) begin
                        state_q           <= ST_WAIT;
                        ch_q              <= '0;
                        wcnt_q            <= WC_W'(ACC_LATENCY - 1);
                        Enable_SO         <= 1'b0;
                        HypervectorOut_DO <= '0;
                        FeatureOut_DO     <= '0;
                        ChannelIdx_DO     <= '0;
                    end else begin
                        ch_q              <= ch_nxt;
                        HypervectorOut_DO <= rot_nxt;
                        FeatureOut_DO     <= frame_q[int'(ch_nxt)*CH_W +: CH_W];
                        ChannelIdx_DO     <= ch_nxt;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q    <= ST_DONE;
                        AccDone_SO <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - WC_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q          <= ST_IDLE;
                    AccDone_SO       <= 1'b0;
                    FeaturesReady_SO <= 1'b1;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    FeaturesReady_SO <= 1'b1;
                end
            endcase
        end
    end

endmodule
